// File: rtl/binary_activation_popcount_accumulator.sv
// Binary dot-product back end: popcounts 1-bit product beats, accumulates
// IN_DEPTH beats and emits a signed +/-1 dot product over valid/ready.
module binary_activation_popcount_accumulator #(
    parameter int IN_SIZE   = 4,
    parameter int IN_DEPTH  = 4,
    parameter int IN_WIDTH  = 1,
    parameter int OUT_WIDTH = $clog2(IN_SIZE * IN_DEPTH + 1) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  data_in [IN_SIZE-1:0],
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    localparam int TOTAL  = IN_SIZE * IN_DEPTH;
    localparam int SUM_W  = $clog2(TOTAL + 1);
    localparam int ONES_W = $clog2(IN_SIZE + 1);
    localparam int CNT_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int LEAVES = 1 << $clog2(IN_SIZE);

    localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(IN_DEPTH - 1);
    localparam logic [OUT_WIDTH-1:0] TOTAL_OUT = OUT_WIDTH'(TOTAL);

    logic [CNT_W-1:0]     beat_cnt;
    logic [SUM_W-1:0]     acc;
    logic [SUM_W-1:0]     sum_next;
    logic [ONES_W-1:0]    ones;
    logic [OUT_WIDTH-1:0] result;
    logic                 last_beat;
    logic                 beat_fire;
    logic                 out_fire;

    // Balanced adder tree over a power-of-two leaf row; unused leaves are zero.
    always_comb begin : popcount_tree
        logic [ONES_W-1:0] node [2*LEAVES-1];
        for (int i = 0; i < 2 * LEAVES - 1; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < IN_SIZE; i++) begin
            node[LEAVES-1+i] = ONES_W'(data_in[i]);
        end
        for (int i = LEAVES - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
        ones = node[0];
    end

    assign sum_next  = acc + SUM_W'(ones);
    assign last_beat = (beat_cnt == LAST_CNT);

    // ones count n maps to n*(+1) + (TOTAL-n)*(-1) = 2n - TOTAL.
    assign result = OUT_WIDTH'({sum_next, 1'b0}) - TOTAL_OUT;

    // Only the closing beat of a group can be held up by an unaccepted result.
    assign data_in_ready = !last_beat || !data_out_valid || data_out_ready;

    assign beat_fire = data_in_valid && data_in_ready;
    assign out_fire  = data_out_valid && data_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt       <= '0;
            acc            <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            if (out_fire) begin
                data_out_valid <= 1'b0;
            end
            if (beat_fire) begin
                if (last_beat) begin
                    data_out       <= result;
                    data_out_valid <= 1'b1;
                    acc            <= '0;
                    beat_cnt       <= '0;
                end else begin
                    acc      <= sum_next;
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_binary_activation_popcount_accumulator.sv
// Bench for the popcount accumulator: directed group cases, backpressure,
// mid-group reset, a random stream vs a group model, and an IN_DEPTH=1 copy.
module tb_binary_activation_popcount_accumulator;

    localparam int IN_SIZE  = 4;
    localparam int IN_DEPTH = 4;
    localparam int OW       = $clog2(IN_SIZE * IN_DEPTH + 1) + 1;
    localparam int OW1      = $clog2(IN_SIZE + 1) + 1;

    logic          clk;
    logic          rst;
    logic [3:0]    bits;
    logic [0:0]    din [3:0];
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] dout;
    logic          out_valid;
    logic          out_ready;

    logic [3:0]     bits1;
    logic [0:0]     din1 [3:0];
    logic           in_valid1;
    logic           in_ready1;
    logic [OW1-1:0] dout1;
    logic           out_valid1;
    logic           out_ready1;

    int total;
    int bad;
    int exp_q[$];
    int m_ones;
    int m_beats;
    bit prev_stall;
    int prev_data;
    bit rand_ready;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            din[i]  = bits[i];
            din1[i] = bits1[i];
        end
    end

    binary_activation_popcount_accumulator #(
        .IN_SIZE (IN_SIZE),
        .IN_DEPTH(IN_DEPTH)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (din),
        .data_in_valid (in_valid),
        .data_in_ready (in_ready),
        .data_out      (dout),
        .data_out_valid(out_valid),
        .data_out_ready(out_ready)
    );

    binary_activation_popcount_accumulator #(
        .IN_SIZE (IN_SIZE),
        .IN_DEPTH(1)
    ) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .data_in       (din1),
        .data_in_valid (in_valid1),
        .data_in_ready (in_ready1),
        .data_out      (dout1),
        .data_out_valid(out_valid1),
        .data_out_ready(out_ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [3:0] b);
        bit done;
        done     = 0;
        bits     = b;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) check("beat_timeout", int'(in_ready), 1);
        in_valid = 1'b0;
    endtask

    // Group-level model: every IN_DEPTH accepted beats yield 2*ones - N.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ones     = 0;
            m_beats    = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'($signed(dout)), prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("extra_result", exp_q.size(), 1);
                else
                    check("result", int'($signed(dout)), exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                m_ones += $countones(bits);
                m_beats++;
                if (m_beats == IN_DEPTH) begin
                    exp_q.push_back(2 * m_ones - IN_SIZE * IN_DEPTH);
                    m_ones  = 0;
                    m_beats = 0;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = int'($signed(dout));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [3:0] g [4];
        total      = 0;
        bad        = 0;
        rand_ready = 0;
        rst        = 1'b1;
        bits       = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        bits1      = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        check("rst_dout", int'(dout), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_valid1", int'(out_valid1), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All ones: +16, valid exactly one cycle after the 4th beat.
        for (int i = 0; i < 3; i++) send_beat(4'b1111);
        check("early_valid", int'(out_valid), 0);
        send_beat(4'b1111);
        check("lat_valid", int'(out_valid), 1);
        check("all_ones", int'($signed(dout)), 16);
        for (int i = 0; i < 4; i++) send_beat(4'b0000);
        check("all_zeros", int'($signed(dout)), -16);
        for (int i = 0; i < 4; i++) send_beat(4'b1010);
        check("alt", int'($signed(dout)), 0);
        g = '{4'b1111, 4'b0000, 4'b0111, 4'b0001};
        foreach (g[i]) send_beat(g[i]);
        check("mixed", int'($signed(dout)), 0);
        g = '{4'b1111, 4'b1111, 4'b1111, 4'b0111};
        foreach (g[i]) send_beat(g[i]);
        check("fourteen", int'($signed(dout)), 14);
        @(posedge clk);
        #1;
        check("drop_valid", int'(out_valid), 0);

        // Backpressure: result held, next group stalls only on its last beat.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(4'b1111);
        check("bp_first", int'($signed(dout)), 16);
        for (int i = 0; i < 3; i++) send_beat(4'b0000);
        bits     = 4'b0000;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_swap_valid", int'(out_valid), 1);
        check("bp_swap_data", int'($signed(dout)), -16);
        @(posedge clk);
        #1;

        // Async reset mid-group discards the partial sum.
        send_beat(4'b1111);
        send_beat(4'b1111);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_dout", int'(dout), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_ready", int'(in_ready), 1);
        for (int i = 0; i < 4; i++) send_beat(4'b0000);
        check("post_rst_group", int'($signed(dout)), -16);

        // Random stream with input gaps and output backpressure.
        rand_ready = 1;
        for (int n = 0; n < 200 * IN_DEPTH; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_beat(4'($urandom));
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("drain", exp_q.size(), 0);
        check("drain_valid", int'(out_valid), 0);

        // IN_DEPTH=1: one result per beat on consecutive cycles.
        bits1     = 4'b1111;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        check("d1_ready", int'(in_ready1), 1);
        check("d1_plus4", int'($signed(dout1)), 4);
        bits1 = 4'b0011;
        @(posedge clk);
        #1;
        check("d1_zero", int'($signed(dout1)), 0);
        check("d1_valid", int'(out_valid1), 1);
        bits1 = 4'b0000;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check("d1_minus4", int'($signed(dout1)), -4);
        @(posedge clk);
        #1;
        check("d1_idle", int'(out_valid1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
